// File: rtl/i2c_codec_writer_pkg.sv
// Shared types and constants for the WM8731 I2C control-word writer.
// State encoding, codec address and byte-index constants.
package codec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [6:0] WM8731_ADDR = 7'h1A;
  localparam int DEF_CLK_DIV = 125;

  localparam logic [1:0] BYTE_ADDR = 2'd0;
  localparam logic [1:0] BYTE_LO = 2'd2;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  function automatic logic [7:0] addr_w(
    input logic [6:0] a
  );
    return {a, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_codec_writer_if.sv
// Word handshake between the codec config sequencer and the I2C writer.
// The sequencer is the master; the writer is the slave.
interface i2c_codec_writer_if;
  logic        START;
  logic [15:0] DATA;
  logic        BUSY;
  logic        DONE;
  logic        ACK_ERR;

  modport master (
    output START,
    output DATA,
    input  BUSY,
    input  DONE,
    input  ACK_ERR
  );

  modport slave (
    input  START,
    input  DATA,
    output BUSY,
    output DONE,
    output ACK_ERR
  );
endinterface

// File: rtl/i2c_codec_writer_tick_gen.sv
// Quarter-SCL-period tick divider with synchronous clear.
// Tick is registered, so it lands one MCLK after terminal count.
module i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic clr,
  output logic tick
);

  localparam int CW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC =
    CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == TC);
      cnt  <= (cnt == TC) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_codec_writer.sv
// Write-only I2C master: START, addr+W, two data bytes, STOP.
// One WM8731 16-bit control word per accepted request.
module i2c_codec_writer
  import codec_pkg::*;
#(
  parameter int         CLK_DIV  = DEF_CLK_DIV,
  parameter logic [6:0] DEV_ADDR = WM8731_ADDR
) (
  input  logic                MCLK,
  input  logic                RESET,
  i2c_codec_writer_if.slave   host,
  output logic                SCL,
  inout  wire                 SDA
);

  state_t      state, state_n;
  logic [1:0]  qtr, qtr_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [1:0]  byte_idx, byte_n;
  logic [23:0] shift_reg, sr_n;
  logic        ack_err, err_n;
  logic        scl_q, scl_n;
  logic        oe_q, oe_n;
  logic        sda_meta, sda_s;
  logic        tick;
  logic        tick_clr;

  assign tick_clr = (state == S_IDLE);

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .MCLK  (MCLK),
    .RESET (RESET),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // SDA is released in IDLE, so the pulled-up level is the reset value.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      sda_meta <= 1'b1;
      sda_s    <= 1'b1;
    end else begin
      sda_meta <= SDA;
      sda_s    <= sda_meta;
    end
  end

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      qtr       <= Q0;
      bit_cnt   <= '0;
      byte_idx  <= BYTE_ADDR;
      shift_reg <= '0;
      ack_err   <= 1'b0;
      scl_q     <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state     <= state_n;
      qtr       <= qtr_n;
      bit_cnt   <= bit_n;
      byte_idx  <= byte_n;
      shift_reg <= sr_n;
      ack_err   <= err_n;
      scl_q     <= scl_n;
      oe_q      <= oe_n;
    end
  end

  always_comb begin
    state_n = state;
    qtr_n   = qtr;
    bit_n   = bit_cnt;
    byte_n  = byte_idx;
    sr_n    = shift_reg;
    err_n   = ack_err;
    case (state)
      S_IDLE: begin
        if (host.START) begin
          state_n = S_START;
          qtr_n   = Q0;
          bit_n   = '0;
          byte_n  = BYTE_ADDR;
          sr_n    = {addr_w(DEV_ADDR), host.DATA};
          err_n   = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          qtr_n = qtr + 2'd1;
          if (qtr == Q3)
            state_n = S_BIT;
        end
      end
      S_BIT: begin
        if (tick) begin
          qtr_n = qtr + 2'd1;
          if (qtr == Q3) begin
            sr_n  = {shift_reg[22:0], 1'b0};
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state_n = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (tick) begin
          qtr_n = qtr + 2'd1;
          if (qtr == Q2 && sda_s)
            err_n = 1'b1;
          // A NACK on any byte abandons the rest of the frame.
          if (qtr == Q3) begin
            if (ack_err || byte_idx == BYTE_LO) begin
              state_n = S_STOP;
            end else begin
              state_n = S_BIT;
              byte_n  = byte_idx + 2'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          qtr_n = qtr + 2'd1;
          if (qtr == Q3)
            state_n = S_DONE;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Bus levels are decoded from the next phase and registered.
  always_comb begin
    scl_n = 1'b1;
    oe_n  = 1'b0;
    unique case (1'b1)
      (state_n == S_START): begin
        scl_n = (qtr_n != Q3);
        oe_n  = (qtr_n != Q0);
      end
      (state_n == S_BIT): begin
        scl_n = qtr_n[0] ^ qtr_n[1];
        oe_n  = ~sr_n[23];
      end
      (state_n == S_ACK): begin
        scl_n = qtr_n[0] ^ qtr_n[1];
        oe_n  = 1'b0;
      end
      (state_n == S_STOP): begin
        scl_n = (qtr_n != Q0);
        oe_n  = (qtr_n != Q3);
      end
      default: begin
        scl_n = 1'b1;
        oe_n  = 1'b0;
      end
    endcase
  end

  assign SCL = scl_q;
  assign SDA = oe_q ? 1'b0 : 1'bz;

  assign host.BUSY    = (state != S_IDLE);
  assign host.DONE    = (state == S_DONE);
  assign host.ACK_ERR = ack_err;

endmodule

// File: tb/tb_i2c_codec_writer.sv
// Directed bench for i2c_codec_writer with a byte-level I2C slave model.
// Bus events are logged and compared against hand-built frames.
module tb_i2c_codec_writer;

  logic MCLK = 1'b0;
  logic RESET = 1'b0;
  logic scl;
  wire  sda;
  logic slave_low = 1'b0;
  int   nack_idx = 3;

  i2c_codec_writer_if host ();

  pullup pu (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_codec_writer #(
    .CLK_DIV  (4),
    .DEV_ADDR (7'h1A)
  ) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .host  (host),
    .SCL   (scl),
    .SDA   (sda)
  );

  always #5 MCLK = ~MCLK;

  int errors = 0;
  int checks = 0;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Slave/monitor: 256 = START, 512 = STOP, else a byte.
  int   log_q[$];
  logic scl_p = 1'b1, sda_p = 1'b1;
  logic in_frame = 1'b0, acking = 1'b0;
  int   bitn = 0, bcnt = 0;
  logic [7:0] shreg = '0;

  always @(negedge MCLK) begin
    if (scl_p && scl && sda_p && !sda) begin
      log_q.push_back(256);
      in_frame = 1'b1;
      bitn = 0;
      bcnt = 0;
      acking = 1'b0;
    end else if (scl_p && scl && !sda_p && sda) begin
      log_q.push_back(512);
      in_frame = 1'b0;
    end else if (in_frame && !scl_p && scl) begin
      if (bitn < 8) begin
        shreg = {shreg[6:0], sda};
        bitn++;
      end
    end else if (in_frame && scl_p && !scl) begin
      if (bitn == 8 && !acking) begin
        log_q.push_back(int'(shreg));
        slave_low = (bcnt != nack_idx);
        bcnt++;
        acking = 1'b1;
      end else if (acking) begin
        slave_low = 1'b0;
        acking = 1'b0;
        bitn = 0;
      end
    end
    scl_p = scl;
    sda_p = sda;
  end

  task automatic check_log(
    input string name,
    input int    base,
    input int    exp[$]
  );
    int bad;
    int got_n;
    bad = -1;
    got_n = log_q.size() - base;
    if (got_n != exp.size()) begin
      bad = 0;
    end else begin
      for (int i = exp.size() - 1; i >= 0; i--)
        if (log_q[base + i] != exp[i]) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: got %0d events, idx %0d = %0h, expected %0d events",
               name, got_n, bad,
               (base + bad < log_q.size()) ? log_q[base + bad] : -1,
               exp.size());
    end
  endtask

  task automatic wait_done(output int n);
    int i;
    n = 0;
    i = 0;
    while (n == 0 && i < 3000) begin
      @(posedge MCLK);
      #1;
      i++;
      if (host.DONE) n = i;
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          nack;
    int          lat;
    logic        err;
    int          nb;
    logic [7:0]  b0, b1, b2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int base;
    int exp[$];

    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int base;
    int exp[$];

    vecs[0] = '{16'h0E53, 3, 465, 1'b0, 3, 8'h34, 8'h0E, 8'h53};
    vecs[1] = '{16'h0017, 0, 177, 1'b1, 1, 8'h34, 8'h00, 8'h00};
    vecs[2] = '{16'h1234, 1, 321, 1'b1, 2, 8'h34, 8'h12, 8'h00};
    vecs[3] = '{16'hABCD, 2, 465, 1'b1, 3, 8'h34, 8'hAB, 8'hCD};
    vecs[4] = '{16'h0000, 3, 465, 1'b0, 3, 8'h34, 8'h00, 8'h00};
    vecs[5] = '{16'hFFFF, 3, 465, 1'b0, 3, 8'h34, 8'hFF, 8'hFF};

    host.START = 1'b0;
    host.DATA  = '0;
    repeat (3) @(posedge MCLK);
    #1;
    check("rst_busy", host.BUSY, 1'b0);
    check("rst_done", host.DONE, 1'b0);
    check("rst_ackerr", host.ACK_ERR, 1'b0);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda, 1'b1);
    @(negedge MCLK);
    RESET = 1'b1;

    for (int v = 0; v < 6; v++) begin
      nack_idx = vecs[v].nack;
      base = log_q.size();
      @(negedge MCLK);
      host.DATA  = vecs[v].data;
      host.START = 1'b1;
      @(posedge MCLK);
      #1;
      check("vec_accept", host.BUSY, 1'b1);
      check("vec_errclr", host.ACK_ERR, 1'b0);
      host.START = 1'b0;
      wait_done(n);
      check("vec_latency", n, vecs[v].lat);
      check("vec_ackerr", host.ACK_ERR, vecs[v].err);
      exp = {};
      exp.push_back(256);
      exp.push_back(int'(vecs[v].b0));
      if (vecs[v].nb > 1) exp.push_back(int'(vecs[v].b1));
      if (vecs[v].nb > 2) exp.push_back(int'(vecs[v].b2));
      exp.push_back(512);
      check_log("vec_frame", base, exp);
      @(posedge MCLK);
      #1;
      check("vec_donepulse", host.DONE, 1'b0);
      check("vec_idle", host.BUSY, 1'b0);
      check("vec_errhold", host.ACK_ERR, vecs[v].err);
    end

    // Back-to-back with START held and DATA stepped on DONE.
    nack_idx = 3;
    base = log_q.size();
    @(negedge MCLK);
    host.DATA  = 16'h0017;
    host.START = 1'b1;
    @(posedge MCLK);
    #1;
    check("b2b_accept1", host.BUSY, 1'b1);
    wait_done(n);
    check("b2b_lat1", n, 465);
    host.DATA = 16'h0217;
    @(posedge MCLK);
    #1;
    check("b2b_gap_idle", host.BUSY, 1'b0);
    @(posedge MCLK);
    #1;
    check("b2b_accept2", host.BUSY, 1'b1);
    host.START = 1'b0;
    wait_done(n);
    check("b2b_lat2", n, 465);
    exp = '{256, 'h34, 'h00, 'h17, 512,
            256, 'h34, 'h02, 'h17, 512};
    check_log("b2b_frames", base, exp);
    @(posedge MCLK);

    // Reset in the middle of the second data byte.
    @(negedge MCLK);
    host.DATA  = 16'hA55A;
    host.START = 1'b1;
    @(posedge MCLK);
    #1;
    check("rst_mid_accept", host.BUSY, 1'b1);
    repeat (350) @(posedge MCLK);
    #2;
    RESET = 1'b0;
    #1;
    check("rst_mid_scl", scl, 1'b1);
    check("rst_mid_sda", sda, 1'b1);
    check("rst_mid_busy", host.BUSY, 1'b0);
    check("rst_mid_done", host.DONE, 1'b0);
    host.DATA = 16'h0E53;
    for (int i = 0; i < 3; i++) begin
      @(negedge MCLK);
      check("rst_hold_done", host.DONE, 1'b0);
    end
    base = log_q.size();
    RESET = 1'b1;
    @(posedge MCLK);
    #1;
    check("rst_rel_accept", host.BUSY, 1'b1);
    host.START = 1'b0;
    wait_done(n);
    check("rst_rel_lat", n, 465);
    exp = '{256, 'h34, 'h0E, 'h53, 512};
    check_log("rst_rel_frame", base, exp);
    @(posedge MCLK);

    // DATA and START changes while busy are ignored.
    base = log_q.size();
    @(negedge MCLK);
    host.DATA  = 16'h1201;
    host.START = 1'b1;
    @(posedge MCLK);
    #1;
    check("chg_accept", host.BUSY, 1'b1);
    host.DATA = 16'hFFFF;
    repeat (100) @(posedge MCLK);
    #1;
    host.START = 1'b0;
    wait_done(n);
    check("chg_lat", n + 100, 465);
    check("chg_ackerr", host.ACK_ERR, 1'b0);
    exp = '{256, 'h34, 'h12, 'h01, 512};
    check_log("chg_frame", base, exp);
    @(posedge MCLK);
    #1;
    check("chg_idle", host.BUSY, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
